frame_collector: RTL and testbench
==================================

FRAME_COLLECTOR -- requirements
Module: frame_collector

Interface
REQ-001 Parameter FRAME_LEN, default 9: bytes per frame, matching the 9-phase upstream byte sequencer.
REQ-002 Parameter DW, default 8: byte width.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_data  input  DW  byte from the upstream sequencer output.
REQ-006 in_valid  input  1  in_data valid this cycle; there is no backpressure to upstream.
REQ-007 in_sof  input  1  qualifies in_data as frame byte 0; upstream phase 0.
REQ-008 out_frame  output  FRAME_LEN*DW  assembled frame; byte i at bits [i*DW+DW-1 : i*DW].
REQ-009 out_valid  output  1  out_frame holds a complete frame.
REQ-010 out_ready  input  1  consumer accepts out_frame when out_valid && out_ready.
REQ-011 drop_cnt  output  8  count of frames dropped because the output register was occupied; saturating.
REQ-012 sync_err  output  1  one-cycle pulse when a frame restarts before completion.

Function
REQ-013 The block SHALL be a two-state FSM with states HUNT and COLLECT and a byte index idx of width clog2(FRAME_LEN).
REQ-014 In HUNT, a byte with in_valid && !in_sof SHALL be ignored.
REQ-015 In HUNT or COLLECT, in_valid && in_sof SHALL write the byte to collect slot 0, set idx to 1, and enter COLLECT.
REQ-016 In COLLECT, in_valid && !in_sof SHALL write the byte to slot idx and increment idx.
REQ-017 Cycles with !in_valid SHALL leave state, idx and the collect buffer unchanged.
REQ-018 In COLLECT, in_sof with idx != 0 SHALL pulse sync_err for one cycle, discard the partial frame, and restart at slot 0 with the current byte.
REQ-019 A write to slot FRAME_LEN-1 SHALL complete the frame, set idx to 0, and return to HUNT.
REQ-020 On completion, if out_valid is 0 or out_ready is 1 in that cycle, the frame (including the final byte) SHALL load into out_frame and out_valid SHALL be 1 on the next cycle, giving a latency of 1 cycle after the last byte.
REQ-021 On completion with out_valid=1 and out_ready=0, the frame SHALL be dropped and drop_cnt SHALL increment, saturating at 255.
REQ-022 out_frame SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 A handshake without a simultaneous completion SHALL clear out_valid on the next cycle.
REQ-024 The collect buffer SHALL be separate from out_frame, so collection continues while the output waits.

Reset
REQ-025 While rst=1, the block SHALL set state HUNT, idx 0, out_valid 0, out_frame 0, drop_cnt 0, and sync_err 0.
REQ-026 Reset during COLLECT SHALL discard the partial frame without asserting sync_err or incrementing drop_cnt.
REQ-027 in_valid SHALL be ignored in any cycle with rst=1.

Configuration
REQ-028 With macro FRAME_COLLECTOR_CHK_EN defined, the block SHALL have output out_chk [DW-1:0], equal to the XOR of all FRAME_LEN bytes of out_frame and updated and held together with out_frame, with reset value 0.
REQ-029 Without FRAME_COLLECTOR_CHK_EN, the out_chk port and the XOR logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package frame_pkg SHALL hold FRAME_LEN and DW defaults, the FSM state enum (HUNT, COLLECT), and the DROP_CNT_W=8 constant.
REQ-031 Sub-module frame_xor_acc SHALL hold the running XOR (clear on sof, accumulate on valid byte); it SHALL be instantiated only under FRAME_COLLECTOR_CHK_EN.

Verification
REQ-032 The bench SHALL drive sof+0x10, then 0x11..0x18 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after 0x18, with out_frame bytes 0..8 equal to 0x10..0x18.
REQ-033 The bench SHALL send bytes 0x55,0x66 with no sof after reset -> ignored, out_valid stays 0.
REQ-034 The bench SHALL send sof+0xA0,0xA1,0xA2, then sof+0xB0 and 8 more bytes -> sync_err pulses once, and the output frame starts 0xB0.
REQ-035 The bench SHALL send two full frames with out_ready=0 -> first frame held unchanged, drop_cnt=1; then out_ready=1 -> out_valid drops the next cycle.
REQ-036 The bench SHALL assert rst after byte 4 of a frame, then send a full frame -> only the second frame appears, with sync_err=0 and drop_cnt=0.
REQ-037 With FRAME_COLLECTOR_CHK_EN defined, the bench SHALL send frame 0x01,0x02,0x04,..,0x80,0xFF -> out_chk=0x00; with frame 0x01 followed by eight 0x00 bytes -> out_chk=0x01.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants and types for the frame collector.
// The optional checksum output is enabled with the macro FRAME_COLLECTOR_CHK_EN.
package frame_pkg;

    localparam int unsigned FRAME_LEN_DEF = 9;
    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned DROP_CNT_W    = 8;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/frame_xor_acc.sv
// Running XOR of the bytes of the frame being collected.
// Built only when FRAME_COLLECTOR_CHK_EN is defined.
module frame_xor_acc #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          accum_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] acc_o,
    output logic [DW-1:0] acc_next_c
);

    logic [DW-1:0] acc_q;

    // A start-of-frame byte restarts the sum; later bytes fold in.
    always_comb begin
        acc_next_c = acc_q;
        if (load_i) begin
            acc_next_c = data_i;
        end else if (accum_i) begin
            acc_next_c = acc_q ^ data_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_next_c;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/frame_collector.sv
// Assembles FRAME_LEN bytes from the upstream sequencer into one output frame.
// Define FRAME_COLLECTOR_CHK_EN to add the out_chk XOR checksum output.
module frame_collector
    import frame_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned DW        = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           in_data,
    input  logic                    in_valid,
    input  logic                    in_sof,
    output logic [FRAME_LEN*DW-1:0] out_frame,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DROP_CNT_W-1:0]   drop_cnt,
    output logic                    sync_err
`ifdef FRAME_COLLECTOR_CHK_EN
    ,
    output logic [DW-1:0]           out_chk
`endif
);

    localparam int unsigned IDX_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned FRAME_W = FRAME_LEN * DW;

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [FRAME_W-1:0]      buf_q;
    logic [FRAME_W-1:0]      out_frame_q;
    logic                    out_valid_q;
    logic [DROP_CNT_W-1:0]   drop_cnt_q;
    logic                    sync_err_q;

    logic                    wr_en_c;
    logic [IDX_W-1:0]        wr_slot_c;
    logic                    restart_c;
    logic                    complete_c;
    logic                    load_out_c;
    logic [FRAME_W-1:0]      frame_c;

    // Decode which slot (if any) the incoming byte lands in, and the frame it produces.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_slot_c = '0;
        restart_c = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                wr_en_c   = 1'b1;
                wr_slot_c = '0;
                restart_c = (state_q == COLLECT) && (idx_q != '0);
            end else if (state_q == COLLECT) begin
                wr_en_c   = 1'b1;
                wr_slot_c = idx_q;
            end
        end

        frame_c = buf_q;
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            if (wr_en_c && (wr_slot_c == IDX_W'(i))) begin
                frame_c[i*DW +: DW] = in_data;
            end
        end

        complete_c = wr_en_c && (wr_slot_c == IDX_W'(FRAME_LEN - 1));
        load_out_c = complete_c && (!out_valid_q || out_ready);
    end

`ifdef FRAME_COLLECTOR_CHK_EN
    logic [DW-1:0] acc_unused;
    logic [DW-1:0] acc_next_c;
    logic [DW-1:0] out_chk_q;

    frame_xor_acc #(
        .DW (DW)
    ) u_xor_acc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (in_valid && in_sof),
        .accum_i    (wr_en_c && !in_sof),
        .data_i     (in_data),
        .acc_o      (acc_unused),
        .acc_next_c (acc_next_c)
    );

    // Checksum is captured together with the frame it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_chk_q <= '0;
        end else if (load_out_c) begin
            out_chk_q <= acc_next_c;
        end
    end

    assign out_chk = out_chk_q;
`endif

    // Collection FSM, output register, drop counter and sync error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            buf_q       <= '0;
            out_frame_q <= '0;
            out_valid_q <= 1'b0;
            drop_cnt_q  <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            sync_err_q <= restart_c;

            if (wr_en_c) begin
                buf_q <= frame_c;
                if (complete_c) begin
                    state_q <= HUNT;
                    idx_q   <= '0;
                end else begin
                    state_q <= COLLECT;
                    idx_q   <= wr_slot_c + IDX_W'(1);
                end
            end

            if (complete_c) begin
                if (load_out_c) begin
                    out_frame_q <= frame_c;
                    out_valid_q <= 1'b1;
                end else if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
                    drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_frame = out_frame_q;
    assign out_valid = out_valid_q;
    assign drop_cnt  = drop_cnt_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_frame_collector.sv
// Self-checking bench for frame_collector: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_frame_collector;

    localparam int unsigned FL = 9;
    localparam int unsigned DW = 8;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_sof;
    logic [FL*DW-1:0]  out_frame;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        drop_cnt;
    logic              sync_err;
`ifdef FRAME_COLLECTOR_CHK_EN
    logic [DW-1:0]     out_chk;
`endif

    int checks = 0;
    int errors = 0;

    frame_collector #(
        .FRAME_LEN (FL),
        .DW        (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .out_frame (out_frame),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt),
        .sync_err  (sync_err)
`ifdef FRAME_COLLECTOR_CHK_EN
        ,
        .out_chk   (out_chk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [DW-1:0] byte_of(input logic [FL*DW-1:0] f, input int i);
        return f[i*DW +: DW];
    endfunction

    // ---------------- reference model ----------------
    logic [DW-1:0]    m_cur[$];
    bit               m_init = 0;
    bit               m_valid;
    logic [FL*DW-1:0] m_frame;
    int               m_drop;
    bit               m_serr;
    logic [DW-1:0]    m_chk;

    always @(posedge clk) begin
        logic [FL*DW-1:0] f;
        logic [DW-1:0]    x;
        bit               done;
        if (rst) begin
            m_init  = 1;
            m_cur.delete();
            m_valid = 0;
            m_frame = '0;
            m_drop  = 0;
            m_serr  = 0;
            m_chk   = '0;
        end else if (m_init) begin
            m_serr = 0;
            done   = 0;
            if (in_valid) begin
                if (in_sof) begin
                    if (m_cur.size() > 0) m_serr = 1;
                    m_cur.delete();
                    m_cur.push_back(in_data);
                end else if (m_cur.size() > 0) begin
                    m_cur.push_back(in_data);
                end
            end
            if (m_cur.size() == FL) begin
                done = 1;
                x = '0;
                for (int i = 0; i < int'(FL); i++) begin
                    f[i*DW +: DW] = m_cur[i];
                    x ^= m_cur[i];
                end
                m_cur.delete();
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    m_frame = f;
                    m_valid = 1;
                    m_chk   = x;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_init) begin
            chk("model_out_valid", 128'(out_valid), 128'(m_valid));
            chk("model_out_frame", 128'(out_frame), 128'(m_frame));
            chk("model_drop_cnt", 128'(drop_cnt), 128'(m_drop));
            chk("model_sync_err", 128'(sync_err), 128'(m_serr));
`ifdef FRAME_COLLECTOR_CHK_EN
            chk("model_out_chk", 128'(out_chk), 128'(m_chk));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        step(1'b1, 1'b1, base);
        for (int i = 1; i < int'(FL); i++) step(1'b1, 1'b0, base + DW'(i));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state.
        do_reset();
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_frame", 128'(out_frame), 128'(0));
        chk("reset_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("reset_sync_err", 128'(sync_err), 128'(0));

        // Basic frame, latency of one cycle after the last byte.
        out_ready = 1'b1;
        send_frame(8'h10);
        chk("basic_valid", 128'(out_valid), 128'(1));
        for (int i = 0; i < int'(FL); i++)
            chk("basic_byte", 128'(byte_of(out_frame, i)), 128'(8'h10 + i));
        step(1'b0, 1'b0, '0);
        chk("basic_handshake_clear", 128'(out_valid), 128'(0));

        // Bytes without sof are ignored in hunt.
        do_reset();
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h66);
        step(1'b0, 1'b0, '0);
        chk("hunt_ignore_valid", 128'(out_valid), 128'(0));

        // Restart mid-frame.
        do_reset();
        step(1'b1, 1'b1, 8'hA0);
        step(1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        chk("restart_no_err_yet", 128'(sync_err), 128'(0));
        step(1'b1, 1'b1, 8'hB0);
        chk("restart_sync_err", 128'(sync_err), 128'(1));
        for (int i = 1; i < int'(FL); i++) begin
            step(1'b1, 1'b0, 8'hB0 + DW'(i));
            chk("restart_err_once", 128'(sync_err), 128'(0));
        end
        chk("restart_valid", 128'(out_valid), 128'(1));
        chk("restart_byte0", 128'(byte_of(out_frame, 0)), 128'(8'hB0));
        chk("restart_byte8", 128'(byte_of(out_frame, 8)), 128'(8'hB8));

        // Output occupied: second frame dropped, first held.
        do_reset();
        out_ready = 1'b0;
        send_frame(8'h20);
        send_frame(8'h30);
        chk("drop_valid", 128'(out_valid), 128'(1));
        chk("drop_held_byte0", 128'(byte_of(out_frame, 0)), 128'(8'h20));
        chk("drop_held_byte8", 128'(byte_of(out_frame, 8)), 128'(8'h28));
        chk("drop_cnt_one", 128'(drop_cnt), 128'(1));
        out_ready = 1'b1;
        step(1'b0, 1'b0, '0);
        chk("drop_release", 128'(out_valid), 128'(0));

        // Reset mid-frame discards it quietly; in_valid ignored while in reset.
        do_reset();
        out_ready = 1'b1;
        step(1'b1, 1'b1, 8'h40);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'h40 + DW'(i));
        rst = 1'b1;
        step(1'b1, 1'b1, 8'h45);
        rst = 1'b0;
        chk("rst_mid_valid", 128'(out_valid), 128'(0));
        send_frame(8'h50);
        chk("rst_mid_after_valid", 128'(out_valid), 128'(1));
        chk("rst_mid_byte0", 128'(byte_of(out_frame, 0)), 128'(8'h50));
        chk("rst_mid_byte4", 128'(byte_of(out_frame, 4)), 128'(8'h54));
        chk("rst_mid_sync_err", 128'(sync_err), 128'(0));
        chk("rst_mid_drop", 128'(drop_cnt), 128'(0));

`ifdef FRAME_COLLECTOR_CHK_EN
        // Checksum of known frames.
        step(1'b1, 1'b1, 8'h01);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 8'(1 << i));
        step(1'b1, 1'b0, 8'hFF);
        chk("chk_zero", 128'(out_chk), 128'(8'h00));
        step(1'b1, 1'b1, 8'h01);
        for (int i = 1; i < int'(FL); i++) step(1'b1, 1'b0, 8'h00);
        chk("chk_one", 128'(out_chk), 128'(8'h01));
`endif

        // Drop counter saturation.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 260; k++) send_frame(8'(k));
        chk("sat_drop_cnt", 128'(drop_cnt), 128'(255));
        chk("sat_held_byte0", 128'(byte_of(out_frame, 0)), 128'(8'h00));

        // Random traffic.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 13) == 0, 8'($urandom));
        end
        rst = 1'b0;
        step(1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
